tdm_demux: RTL
==============

// Module: tdm_demux
// PURPOSE
//  Receive end of the team's 2:1 mux path: recovers NCH channels from one
//  serial TDM bit stream. A frame holds NCH slots of W bits each, MSB first,
//  channel 0 first; a sync strobe marks the first bit of each frame.
//  Each completed slot is presented as a parallel word with its channel
//  index and a one-cycle valid pulse.
// PARAMETERS
//  NCH  2  number of TDM channels per frame (>=2)
//  W    8  bits per channel slot (>=2)
//  CW   1  width of channel index, = clog2(NCH)
// PORTS
//  clk     in   1    rising-edge clock
//  rst     in   1    synchronous, active-high reset
//  en      in   1    bit strobe; din/sync sampled only on edges where en=1
//  din     in   1    serial TDM data bit
//  sync    in   1    high with the first bit of a frame (slot 0, MSB)
//  word    out  W    last completed slot, MSB = first received bit
//  ch      out  CW   channel index of word
//  valid   out  1    one-cycle pulse: word/ch updated this cycle
//  locked  out  1    1 while the FSM is in RECV
//  err     out  1    one-cycle pulse: framing error detected
// BEHAVIOUR
//  Reset (rst=1 at an edge): state=HUNT, bit counter=0, channel counter=0,
//   shift register=0, word=0, ch=0, valid=0, locked=0, err=0. rst has
//   priority over every other input; reset mid-frame discards partial data.
//  All inputs are ignored on edges with en=0; valid and err are then 0 and
//   counters, word and ch hold.
//  HUNT: en=1, sync=0 -> bit discarded, stay HUNT. en=1, sync=1 -> din
//   shifted in, bitcnt=1, chcnt=0, go RECV.
//  RECV, en=1 (bitcnt, chcnt are the values before the edge):
//   - bitcnt<W-1, sync=0: shift din in, bitcnt+1.
//   - bitcnt==W-1, sync=0: word<={sreg[W-2:0],din}, ch<=chcnt, valid=1
//     for the following cycle; bitcnt=0; chcnt+1, wrapping NCH-1 -> 0.
//   - Frame boundary (bitcnt==0, chcnt==0), sync=1: normal frame start;
//     shift din in, bitcnt=1.
//   - Frame boundary, sync=0: missing sync -> err=1, bit discarded, go HUNT.
//   - Not at a frame boundary, sync=1: misplaced sync -> err=1, partial
//     slot discarded with no valid; the bit is taken as the first bit of a
//     new frame (bitcnt=1, chcnt=0), stay RECV.
//  valid and err are never both 1 in the same cycle.
//  Latency: valid is high in the cycle right after the edge that samples
//   the last bit of a slot. word and ch hold until the next valid.
//  locked = (state==RECV), registered.
//  Slot completion and wrap at the last channel coincide: the word carries
//   ch=NCH-1 and the next sampled bit must carry sync.
// TESTING (NCH=2, W=8 unless noted)
//  1 Reset: rst high 2 cycles with en=1 and random din -> word=0, ch=0,
//    valid=0, locked=0, err=0.
//  2 Two clean frames, en=1 continuous, sync on bits 0 and 16, data A5,3C
//    then FF,00 -> valid pulses at cycles 8, 16, 24, 32 (after the first
//    sync edge) with (ch,word) = (0,A5), (1,3C), (0,FF), (1,00); err never 1.
//  3 en gaps: same frame with en=0 on every other cycle -> same words, same
//    order; no pulse on en=0 cycles; word/ch stable between pulses.
//  4 Misplaced sync at bit 5 of slot 0 -> err pulse, no valid for the
//    partial slot, locked stays 1; the next 16 bits decode as a full frame.
//  5 Missing sync at bit 16 -> err pulse, locked=0, no valid until the next
//    sync; the following frame decodes correctly.
//  6 rst asserted at bit 11 -> all outputs return to their reset values;
//    no valid until a new sync; NCH=4, W=4 rerun of scenario 2 checks
//    ch=0,1,2,3 and the wrap back to 0.

Source files
------------

// File: rtl/tdm_demux_if.sv
// Bundle of the TDM receive-side signals: serial input with bit strobe and sync,
// recovered parallel word with channel tag and status pulses.
interface tdm_demux_if #(
  parameter int NCH = 2,
  parameter int W   = 8,
  parameter int CW  = 1
);
  logic          en;
  logic          din;
  logic          sync;
  logic [W-1:0]  word;
  logic [CW-1:0] ch;
  logic          valid;
  logic          locked;
  logic          err;

  modport master (
    output en, din, sync,
    input  word, ch, valid, locked, err
  );

  modport slave (
    input  en, din, sync,
    output word, ch, valid, locked, err
  );
endinterface

// File: rtl/tdm_demux.sv
// Serial TDM receiver: recovers NCH channels of W-bit MSB-first slots from one
// bit stream framed by a sync strobe, flagging missing or misplaced syncs.
module tdm_demux #(
  parameter int NCH = 2,
  parameter int W   = 8,
  parameter int CW  = 1
) (
  input  logic        clk,
  input  logic        rst,
  tdm_demux_if.slave  bus
);
  localparam int            BW       = $clog2(W);
  localparam logic [BW-1:0] LAST_BIT = BW'(W - 1);
  localparam logic [CW-1:0] LAST_CH  = CW'(NCH - 1);

  typedef enum logic {HUNT, RECV} state_t;

  state_t        state_q, state_d;
  logic [BW-1:0] bitcnt_q, bitcnt_d;
  logic [CW-1:0] chcnt_q, chcnt_d;
  logic [W-1:0]  sreg_q, sreg_d;
  logic [W-1:0]  word_q, word_d;
  logic [CW-1:0] ch_q, ch_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;
  logic          locked_q;

  logic [W-1:0]  shifted;
  logic          at_boundary;

  assign shifted     = {sreg_q[W-2:0], bus.din};
  assign at_boundary = (bitcnt_q == '0) && (chcnt_q == '0);

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    chcnt_d  = chcnt_q;
    sreg_d   = sreg_q;
    word_d   = word_q;
    ch_d     = ch_q;
    valid_d  = 1'b0;
    err_d    = 1'b0;
    if (bus.en) begin
      case (state_q)
        HUNT: begin
          if (bus.sync) begin
            sreg_d   = shifted;
            bitcnt_d = BW'(1);
            chcnt_d  = '0;
            state_d  = RECV;
          end
        end
        RECV: begin
          if (bus.sync) begin
            // A sync anywhere restarts the frame; only off-boundary ones are errors.
            err_d    = !at_boundary;
            sreg_d   = shifted;
            bitcnt_d = BW'(1);
            chcnt_d  = '0;
          end else if (at_boundary) begin
            err_d    = 1'b1;
            state_d  = HUNT;
          end else if (bitcnt_q == LAST_BIT) begin
            sreg_d   = shifted;
            word_d   = shifted;
            ch_d     = chcnt_q;
            valid_d  = 1'b1;
            bitcnt_d = '0;
            chcnt_d  = (chcnt_q == LAST_CH) ? '0 : chcnt_q + CW'(1);
          end else begin
            sreg_d   = shifted;
            bitcnt_d = bitcnt_q + BW'(1);
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= HUNT;
      bitcnt_q <= '0;
      chcnt_q  <= '0;
      sreg_q   <= '0;
      word_q   <= '0;
      ch_q     <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      chcnt_q  <= chcnt_d;
      sreg_q   <= sreg_d;
      word_q   <= word_d;
      ch_q     <= ch_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      locked_q <= (state_d == RECV);
    end
  end

  assign bus.word   = word_q;
  assign bus.ch     = ch_q;
  assign bus.valid  = valid_q;
  assign bus.locked = locked_q;
  assign bus.err    = err_q;
endmodule
